// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//   Two-client arbiter in front of an SDRAM controller with separate read and
//   write request ports. One operation is in flight at a time:
//   IDLE -> ISSUE (controller request held until ack or timeout) -> RESP
//   (one-cycle completion pulse to the granted client) -> IDLE.
//
//   Build option: define SDRAM_ARB_RR_EN for round-robin arbitration between
//   the clients; leave it undefined for fixed priority (client 0 wins ties).
//
// Ports
//   iclk, ireset                : clock, asynchronous active-high reset
//   ireqN/iweN/iaddrN/iwdataN   : client N level request, op (1=write), addr, data
//   oackN/ordataN               : client N completion pulse, read data
//   oerr                        : pulses with oack when the op timed out
//   owrite_req/_address/_data   : controller write port
//   oread_req/oread_address     : controller read port
//   iwrite_ack/iread_ack/iread_data : controller completion pulses, read data
//   obusy, ocur_port            : operation in progress, granted client index
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        ireq0,
  input  logic        ireq1,
  input  logic        iwe0,
  input  logic        iwe1,
  input  logic [21:0] iaddr0,
  input  logic [21:0] iaddr1,
  input  logic [15:0] iwdata0,
  input  logic [15:0] iwdata1,
  output logic        oack0,
  output logic        oack1,
  output logic [15:0] ordata0,
  output logic [15:0] ordata1,
  output logic        oerr,
  output logic        owrite_req,
  output logic [21:0] owrite_address,
  output logic [15:0] owrite_data,
  output logic        oread_req,
  output logic [21:0] oread_address,
  input  logic        iwrite_ack,
  input  logic        iread_ack,
  input  logic [15:0] iread_data,
  output logic        obusy,
  output logic        ocur_port
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  // The counter holds the number of ISSUE cycles already spent, so comparing
  // against TIMEOUT_CYCLES-1 keeps the request high for exactly TIMEOUT_CYCLES.
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        cur_port_q, cur_port_d;
  logic        we_q, we_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wreq_q, wreq_d;
  logic        rreq_q, rreq_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        busy_q, busy_d;
  logic [9:0]  cnt_q, cnt_d;
`ifdef SDRAM_ARB_RR_EN
  logic        ptr_q, ptr_d;      // client preferred on the next tie
`endif

  logic        win;
  logic        ack_match;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    cur_port_d = cur_port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wreq_d     = wreq_q;
    rreq_d     = rreq_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    cnt_d      = cnt_q;
`ifdef SDRAM_ARB_RR_EN
    ptr_d      = ptr_q;
    // A lone requester always wins; only a tie consults the pointer.
    win        = (ireq0 && ireq1) ? ptr_q : ireq1;
`else
    win        = ~ireq0;
`endif
    ack_match  = we_q ? iwrite_ack : iread_ack;

    unique case (state_q)
      IDLE: begin
        if (ireq0 || ireq1) begin
          state_d    = ISSUE;
          cur_port_d = win;
          we_d       = win ? iwe1    : iwe0;
          addr_d     = win ? iaddr1  : iaddr0;
          wdata_d    = win ? iwdata1 : iwdata0;
          wreq_d     = win ? iwe1    : iwe0;
          rreq_d     = win ? ~iwe1   : ~iwe0;
          cnt_d      = '0;
`ifdef SDRAM_ARB_RR_EN
          ptr_d      = ~win;
`endif
        end
      end
      ISSUE: begin
        // A matching ack wins over a timeout landing on the same cycle; the
        // ack for the other direction is simply not looked at.
        if (ack_match || (cnt_q == TIMEOUT_LAST)) begin
          state_d = RESP;
          wreq_d  = 1'b0;
          rreq_d  = 1'b0;
          cnt_d   = '0;
          ack0_d  = ~cur_port_q;
          ack1_d  = cur_port_q;
          err_d   = ~ack_match;
          if (ack_match && !we_q) begin
            if (cur_port_q) rdata1_d = iread_data;
            else            rdata0_d = iread_data;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= IDLE;
      cur_port_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wreq_q     <= 1'b0;
      rreq_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
`ifdef SDRAM_ARB_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wreq_q     <= wreq_d;
      rreq_q     <= rreq_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
`ifdef SDRAM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign oack0          = ack0_q;
  assign oack1          = ack1_q;
  assign ordata0        = rdata0_q;
  assign ordata1        = rdata1_q;
  assign oerr           = err_q;
  assign owrite_req     = wreq_q;
  assign owrite_address = addr_q;
  assign owrite_data    = wdata_q;
  assign oread_req      = rreq_q;
  assign oread_address  = addr_q;
  assign obusy          = busy_q;
  assign ocur_port      = cur_port_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//   Directed bench for sdram_port_arbiter. A client process issues operations
//   and pushes the expected completion into a scoreboard queue; a monitor pops
//   and compares on every oack. A small controller model answers requests
//   after a programmable delay and watches request/address stability.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int TMO = 16;

  logic        iclk;
  logic        ireset;
  logic        ireq0, ireq1, iwe0, iwe1;
  logic [21:0] iaddr0, iaddr1;
  logic [15:0] iwdata0, iwdata1;
  logic        oack0, oack1, oerr;
  logic [15:0] ordata0, ordata1;
  logic        owrite_req, oread_req;
  logic [21:0] owrite_address, oread_address;
  logic [15:0] owrite_data;
  logic        iwrite_ack, iread_ack;
  logic [15:0] iread_data;
  logic        obusy, ocur_port;

  sdram_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .iclk(iclk), .ireset(ireset),
    .ireq0(ireq0), .ireq1(ireq1), .iwe0(iwe0), .iwe1(iwe1),
    .iaddr0(iaddr0), .iaddr1(iaddr1), .iwdata0(iwdata0), .iwdata1(iwdata1),
    .oack0(oack0), .oack1(oack1), .ordata0(ordata0), .ordata1(ordata1),
    .oerr(oerr),
    .owrite_req(owrite_req), .owrite_address(owrite_address),
    .owrite_data(owrite_data),
    .oread_req(oread_req), .oread_address(oread_address),
    .iwrite_ack(iwrite_ack), .iread_ack(iread_ack), .iread_data(iread_data),
    .obusy(obusy), .ocur_port(ocur_port)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected completions
  typedef struct packed {
    logic        port;
    logic        err;
    logic [15:0] d0;
    logic [15:0] d1;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] m_ord0, m_ord1;   // expected ordata values after each completion

  always @(negedge iclk) begin
    if (oack0 || oack1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, oack1, oack0}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", {30'd0, oack1, oack0}, mon_e.port ? 32'd2 : 32'd1);
        check("ack_err", oerr, mon_e.err);
        check("ack_cur_port", ocur_port, mon_e.port);
        check("ordata0", ordata0, mon_e.d0);
        check("ordata1", ordata1, mon_e.d1);
      end
    end else if (oerr) begin
      check("err_without_ack", oerr, 1'b0);
    end
  end

  // Controller model
  int          ack_delay = 0;     // req-high cycles before ack; 0 = never ack
  int          req_cycles = 0;
  int          last_req_len = 0;
  logic [21:0] lat_addr;
  logic [15:0] lat_data;
  logic [21:0] cur_addr;
  logic        model_wack = 1'b0, model_rack = 1'b0;
  logic        stray_wack = 1'b0, stray_rack = 1'b0;
  logic [15:0] model_rdata = 16'h0;
  logic [15:0] mem [logic [21:0]];

  assign iwrite_ack = model_wack | stray_wack;
  assign iread_ack  = model_rack | stray_rack;
  assign iread_data = model_rdata;

  always @(negedge iclk) begin
    model_wack = 1'b0;
    model_rack = 1'b0;
    if (owrite_req || oread_req) begin
      check("single_req", owrite_req & oread_req, 1'b0);
      cur_addr = owrite_req ? owrite_address : oread_address;
      req_cycles++;
      if (req_cycles == 1) begin
        lat_addr = cur_addr;
        lat_data = owrite_data;
      end else begin
        check("addr_stable", cur_addr, lat_addr);
        check("data_stable", owrite_data, lat_data);
      end
      if (ack_delay != 0 && req_cycles == ack_delay) begin
        if (owrite_req) begin
          mem[cur_addr] = owrite_data;
          model_wack = 1'b1;
        end else begin
          model_rdata = mem.exists(cur_addr) ? mem[cur_addr] : 16'h0;
          model_rack = 1'b1;
        end
      end
    end else if (req_cycles != 0) begin
      last_req_len = req_cycles;
      req_cycles = 0;
    end
  end

  // Client helpers
  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [21:0] addr, input logic [15:0] wdata);
    if (port) begin
      ireq1 = req; iwe1 = we; iaddr1 = addr; iwdata1 = wdata;
    end else begin
      ireq0 = req; iwe0 = we; iaddr0 = addr; iwdata0 = wdata;
    end
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    ireq0 = 1'b0;
    ireq1 = 1'b0;
    m_ord0 = 16'h0;
    m_ord1 = 16'h0;
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    ireset = 1'b0;
  endtask

  task automatic run_op(input bit port, input bit we, input logic [21:0] addr,
                        input logic [15:0] wdata, input int delay,
                        input bit exp_err, input logic [15:0] exp_rdata,
                        input int exp_len);
    logic got;
    ack_delay = delay;
    if (!we && !exp_err) begin
      if (port) m_ord1 = exp_rdata;
      else      m_ord0 = exp_rdata;
    end
    sb.push_back('{port, exp_err, m_ord0, m_ord1});
    @(posedge iclk); #1;
    drive(port, 1'b1, we, addr, wdata);
    // Sampled at the next edge, controller request visible right after it
    @(posedge iclk); @(negedge iclk);
    check("grant_req", we ? owrite_req : oread_req, 1'b1);
    check("grant_port", ocur_port, port);
    check("grant_busy", obusy, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge iclk);
      got = port ? oack1 : oack0;
    end
    check("ack_seen", got, 1'b1);
    @(posedge iclk); #1;
    drive(port, 1'b0, we, addr, wdata);
    check("req_len", last_req_len, exp_len);
  endtask

  bit exp_g [4];
  int n_acks;

  initial begin
    ireset = 1'b1;
    ireq0 = 1'b0; ireq1 = 1'b0; iwe0 = 1'b0; iwe1 = 1'b0;
    iaddr0 = '0; iaddr1 = '0; iwdata0 = '0; iwdata1 = '0;
    m_ord0 = 16'h0; m_ord1 = 16'h0;

    // Reset state
    @(negedge iclk);
    check("rst_busy", obusy, 1'b0);
    check("rst_reqs", {owrite_req, oread_req}, 2'b00);
    check("rst_acks", {oack0, oack1, oerr}, 3'b000);
    check("rst_cur_port", ocur_port, 1'b0);
    check("rst_addr", owrite_address, 22'h0);
    check("rst_wdata", owrite_data, 16'h0);
    check("rst_ordata", {ordata0, ordata1}, 32'h0);
    do_reset();

    // Port 0 write, ack after 12 cycles
    run_op(1'b0, 1'b1, 22'h000010, 16'hA5A5, 12, 1'b0, 16'h0, 12);

    // Write via port 1, read back via port 0
    run_op(1'b1, 1'b1, 22'h000020, 16'h1234, 3, 1'b0, 16'h0, 3);
    run_op(1'b0, 1'b0, 22'h000020, 16'h0000, 3, 1'b0, 16'h1234, 3);

    // Both clients held high for four operations
    do_reset();
`ifdef SDRAM_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    ack_delay = 2;
    for (int i = 0; i < 4; i++) sb.push_back('{exp_g[i], 1'b0, m_ord0, m_ord1});
    @(posedge iclk); #1;
    drive(1'b0, 1'b1, 1'b1, 22'h000100, 16'h1111);
    drive(1'b1, 1'b1, 1'b1, 22'h000200, 16'h2222);
    n_acks = 0;
    for (int i = 0; i < 100 && n_acks < 4; i++) begin
      @(negedge iclk);
      if (oack0 || oack1) n_acks++;
    end
    check("contention_acks", n_acks, 4);
    @(posedge iclk); #1;
    ireq0 = 1'b0;
    ireq1 = 1'b0;
    repeat (10) @(negedge iclk);
    check("contention_sb_empty", sb.size(), 0);

    // Read with no ack: timeout after TMO cycles, then a stray ack in IDLE
    run_op(1'b0, 1'b0, 22'h000030, 16'h0000, 0, 1'b1, 16'h0, TMO);
    @(negedge iclk);
    stray_rack = 1'b1;
    stray_wack = 1'b1;
    @(negedge iclk);
    stray_rack = 1'b0;
    stray_wack = 1'b0;
    repeat (3) @(negedge iclk);
    check("stray_busy", obusy, 1'b0);
    check("stray_reqs", {owrite_req, oread_req}, 2'b00);

    // Asynchronous reset in the middle of ISSUE
    ack_delay = 0;
    @(posedge iclk); #1;
    drive(1'b0, 1'b1, 1'b1, 22'h000040, 16'h5A5A);
    @(posedge iclk);
    repeat (4) @(negedge iclk);
    check("pre_rst_wreq", owrite_req, 1'b1);
    #2 ireset = 1'b1;
    #1;
    check("async_rst_wreq", owrite_req, 1'b0);
    check("async_rst_busy", obusy, 1'b0);
    @(posedge iclk); #1;
    ireq0 = 1'b0;
    @(negedge iclk);
    ireset = 1'b0;
    repeat (30) @(negedge iclk);
    check("post_rst_busy", obusy, 1'b0);
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d",
             errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
